vram_display_reader: RTL and testbench



---
 rtl/vram_display_reader.sv | 144 ++++++++++++++
 tb/tb_vram_display_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_display_reader.sv
// rtl/vram_display_reader.sv - row fetch engine: VRAM burst reads streamed column-tagged to the row buffer
module vram_display_reader #(
  parameter int ROW_TUPLES   = 320,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_master_clk,
  input  logic        i_reset,
  input  logic [19:0] i_display_address,
  input  logic        i_display_start,
  output logic [8:0]  o_display_column,
  output logic [23:0] o_display_data,
  output logic        o_display_data_valid,
  output logic        o_vram_request,
  input  logic        i_vram_grant,
  output logic        o_vram_read,
  output logic [19:0] o_vram_address,
  input  logic [23:0] i_vram_data,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam logic [9:0] NUM_TUPLES = 10'(ROW_TUPLES);
  localparam logic [9:0] LAST_IDX   = 10'(ROW_TUPLES - 1);
  localparam logic [8:0] LAST_COL   = 9'(ROW_TUPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] base_q, base_d;
  logic [9:0]  issued_q, issued_d;
  logic        issue;

  // Return pipeline: valid bit and column tag per in-flight read.
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [8:0]              pipe_col_q [READ_LATENCY];

  logic        valid_q;
  logic [8:0]  col_q;
  logic [23:0] data_q;
  logic        overrun_q;

  logic pipe_empty;
  logic last_delivered;

  assign pipe_empty     = ~|pipe_vld_q;
  assign last_delivered = valid_q && (col_q == LAST_COL);

  // Next-state logic: burst issue is combinational on grant so every granted cycle issues a read.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    issued_d       = issued_q;
    issue          = 1'b0;
    o_vram_request = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_display_start) begin
          base_d   = i_display_address;
          issued_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_vram_request = 1'b1;
        issue          = i_vram_grant && (issued_q < NUM_TUPLES);
        if (issue) begin
          issued_d = issued_q + 10'd1;
          if (issued_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty && last_delivered) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, base address and issue counter registers.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      issued_q <= issued_d;
    end
  end

  // Valid bits of the latency pipeline; cleared on reset so in-flight returns are dropped.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // Column tags travel alongside the valid bits; only meaningful where the valid bit is set.
  always_ff @(posedge i_master_clk) begin
    pipe_col_q[0] <= issued_q[8:0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_col_q[i] <= pipe_col_q[i-1];
    end
  end

  // Output register: capture returning tuple when the pipeline tail is valid; flag rejected starts.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      col_q     <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= pipe_vld_q[READ_LATENCY-1];
      overrun_q <= i_display_start && (state_q != ST_IDLE);
      if (pipe_vld_q[READ_LATENCY-1]) begin
        col_q  <= pipe_col_q[READ_LATENCY-1];
        data_q <= i_vram_data;
      end
    end
  end

  assign o_vram_read          = issue;
  assign o_vram_address       = base_q + {10'd0, issued_q};
  assign o_display_column     = col_q;
  assign o_display_data       = data_q;
  assign o_display_data_valid = valid_q;
  assign o_busy               = (state_q != ST_IDLE);
  assign o_overrun            = overrun_q;

endmodule

// File: tb/tb_vram_display_reader.sv
// tb/tb_vram_display_reader.sv - self-checking bench for vram_display_reader
module tb_vram_display_reader;

  localparam int R = 320;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [19:0] i_display_address;
  logic        i_display_start;
  logic [8:0]  o_display_column;
  logic [23:0] o_display_data;
  logic        o_display_data_valid;
  logic        o_vram_request;
  logic        i_vram_grant;
  logic        o_vram_read;
  logic [19:0] o_vram_address;
  logic [23:0] i_vram_data;
  logic        o_busy;
  logic        o_overrun;

  logic [19:0] r1_addr_in;
  logic        r1_start;
  logic [8:0]  r1_col;
  logic [23:0] r1_data;
  logic        r1_valid;
  logic        r1_req;
  logic        r1_read;
  logic [19:0] r1_vram_address;
  logic        r1_busy;
  logic        r1_overrun;

  always #5 clk = ~clk;

  vram_display_reader #(.ROW_TUPLES(R), .READ_LATENCY(L)) u_dut (
    .i_master_clk         (clk),
    .i_reset              (i_reset),
    .i_display_address    (i_display_address),
    .i_display_start      (i_display_start),
    .o_display_column     (o_display_column),
    .o_display_data       (o_display_data),
    .o_display_data_valid (o_display_data_valid),
    .o_vram_request       (o_vram_request),
    .i_vram_grant         (i_vram_grant),
    .o_vram_read          (o_vram_read),
    .o_vram_address       (o_vram_address),
    .i_vram_data          (i_vram_data),
    .o_busy               (o_busy),
    .o_overrun            (o_overrun)
  );

  vram_display_reader #(.ROW_TUPLES(1), .READ_LATENCY(L)) u_dut1 (
    .i_master_clk         (clk),
    .i_reset              (i_reset),
    .i_display_address    (r1_addr_in),
    .i_display_start      (r1_start),
    .o_display_column     (r1_col),
    .o_display_data       (r1_data),
    .o_display_data_valid (r1_valid),
    .o_vram_request       (r1_req),
    .i_vram_grant         (1'b1),
    .o_vram_read          (r1_read),
    .o_vram_address       (r1_vram_address),
    .i_vram_data          (24'h123456),
    .o_busy               (r1_busy),
    .o_overrun            (r1_overrun)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic logic [23:0] mem(input logic [19:0] a);
    return {a ^ 20'h5A5A5, a[19:16] + 4'h3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state: row progress counted in tuples, expectations keyed by cycle.
  bit          armed    = 1'b0;
  bit          rst_prev = 1'b0;
  bit          busy_m   = 1'b0;
  logic [19:0] base_m   = '0;
  int          issued_m = 0;
  int          deliv_m  = 0;
  logic [8:0]  exp_col [int];
  logic [23:0] exp_dat [int];
  bit          ovr_e   [int];
  logic [19:0] rd_hist [int];
  bit          exp_req, exp_rd, ev;

  // Per-burst observations used by the hand-computed checks.
  int          t_acc, first_rd, last_vcyc, fall_cyc, ovr_cyc, rd_idx, vcnt, ovr_cnt;
  logic [19:0] first_addr, last_addr, addr16;
  logic [23:0] first_data;
  logic [8:0]  last_col;
  bit          saw4, busy_prev;

  always @(negedge clk) begin
    exp_req = busy_m && (issued_m < R);
    exp_rd  = exp_req && i_vram_grant;
    ev      = 1'b0;
    if (armed) begin
      chk("vram_request", o_vram_request, exp_req);
      chk("vram_read", o_vram_read, exp_rd);
      if (exp_rd) chk("vram_address", o_vram_address, 20'(base_m + 20'(issued_m)));
      chk("busy", o_busy, busy_m);
      chk("overrun", o_overrun, ovr_e.exists(cyc));
      ev = exp_col.exists(cyc);
      chk("data_valid", o_display_data_valid, ev);
      if (ev) begin
        chk("column", o_display_column, exp_col[cyc]);
        chk("data", o_display_data, exp_dat[cyc]);
      end
      if (rst_prev) begin
        chk("reset_data", o_display_data, 0);
        chk("reset_column", o_display_column, 0);
      end
    end
    if (o_vram_read) begin
      if (first_rd < 0) begin
        first_rd   = cyc;
        first_addr = o_vram_address;
      end
      last_addr = o_vram_address;
      if (rd_idx == 16) addr16 = o_vram_address;
      if (o_vram_address == 20'h40000) saw4 = 1'b1;
      rd_idx++;
      rd_hist[cyc] = o_vram_address;
    end
    if (o_display_data_valid) begin
      vcnt++;
      last_vcyc = cyc;
      last_col  = o_display_column;
      if (o_display_column == 9'd0) first_data = o_display_data;
    end
    if (busy_prev && !o_busy) fall_cyc = cyc;
    busy_prev = o_busy;
    if (o_overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    // VRAM: data for a read issued at c is presented during cycle c+L; otherwise junk.
    if (rd_hist.exists(cyc - L)) begin
      i_vram_data = mem(rd_hist[cyc - L]);
      rd_hist.delete(cyc - L);
    end else begin
      i_vram_data = 24'($urandom);
    end
    if (i_reset) begin
      busy_m   = 1'b0;
      issued_m = 0;
      exp_col.delete();
      exp_dat.delete();
      ovr_e.delete();
      rst_prev = 1'b1;
      armed    = 1'b1;
    end else begin
      rst_prev = 1'b0;
      if (ovr_e.exists(cyc)) ovr_e.delete(cyc);
      if (i_display_start) begin
        if (busy_m) begin
          ovr_e[cyc + 1] = 1'b1;
        end else begin
          busy_m = 1'b1; base_m = i_display_address; issued_m = 0; deliv_m = 0;
          t_acc = cyc; first_rd = -1; rd_idx = 0; vcnt = 0; ovr_cnt = 0; saw4 = 1'b0;
          fall_cyc = -1; ovr_cyc = -1; last_vcyc = -1;
        end
      end
      if (exp_rd) begin
        exp_col[cyc + L + 1] = 9'(issued_m);
        exp_dat[cyc + L + 1] = mem(20'(base_m + 20'(issued_m)));
        issued_m++;
      end
      if (ev) begin
        exp_col.delete(cyc);
        exp_dat.delete(cyc);
        deliv_m++;
        if (deliv_m == R) busy_m = 1'b0;
      end
    end
    cyc++;
  end

  bit          r1_en = 1'b0;
  int          r1_rd, r1_vld, r1_busy_cyc;
  logic [19:0] r1_addr_seen;
  logic [8:0]  r1_col_seen;
  logic [23:0] r1_dat_seen;

  always @(negedge clk) begin
    if (r1_en) begin
      if (r1_read) begin
        r1_rd++;
        r1_addr_seen = r1_vram_address;
      end
      if (r1_valid) begin
        r1_vld++;
        r1_col_seen = r1_col;
        r1_dat_seen = r1_data;
      end
      if (r1_busy) r1_busy_cyc++;
    end
  end

  int gmode = 0;
  int gcnt  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    i_display_start = 1'b0;
    r1_start        = 1'b0;
    gcnt++;
    case (gmode)
      0:       i_vram_grant = 1'b1;
      1:       i_vram_grant = (gcnt < 40) ? gcnt[0] : !(gcnt >= 100 && gcnt < 110);
      default: i_vram_grant = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic start_pulse(input logic [19:0] a);
    i_display_start   = 1'b1;
    i_display_address = a;
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_m && n < budget) begin
      step();
      n++;
    end
    chk("idle_within_budget", (n < budget), 1);
    repeat (3) step();
  endtask

  task automatic set_mode(input int m);
    gmode        = m;
    gcnt         = 0;
    i_vram_grant = (m != 1);
  endtask

  initial begin
    i_reset           = 1'b1;
    i_display_start   = 1'b0;
    i_display_address = '0;
    i_vram_grant      = 1'b0;
    r1_start          = 1'b0;
    r1_addr_in        = '0;
    repeat (3) step();
    i_reset = 1'b0;
    step();

    // Continuous grant, plus a start coincident with the final delivery.
    set_mode(0);
    start_pulse(20'h00200);
    repeat (322) step();
    start_pulse(20'h12345);
    wait_idle(50);
    chk("t1_first_read_offset", first_rd - t_acc, 1);
    chk("t1_first_addr", first_addr, 20'h00200);
    chk("t1_last_addr", last_addr, 20'h0033F);
    chk("t1_col0_data", first_data, 24'h5A7A53);
    chk("t1_last_valid_offset", last_vcyc - t_acc, 323);
    chk("t1_last_col", last_col, 319);
    chk("t1_busy_fall_offset", fall_cyc - t_acc, 324);
    chk("t1_end_overrun_offset", ovr_cyc - t_acc, 324);
    chk("t1_overrun_count", ovr_cnt, 1);

    // Toggling grant with a 10-cycle gap.
    set_mode(1);
    start_pulse(20'h00200);
    wait_idle(1000);
    chk("t2_valid_count", vcnt, 320);
    chk("t2_read_count", rd_idx, 320);

    // Address wrap.
    set_mode(0);
    start_pulse(20'hFFFF0);
    wait_idle(500);
    chk("t3_first_addr", first_addr, 20'hFFFF0);
    chk("t3_addr_idx16", addr16, 20'h00000);
    chk("t3_last_addr", last_addr, 20'h0012F);
    chk("t3_valid_count", vcnt, 320);

    // Rejected second start at t+50.
    set_mode(0);
    start_pulse(20'h00200);
    repeat (49) step();
    start_pulse(20'h40000);
    wait_idle(500);
    chk("t4_overrun_offset", ovr_cyc - t_acc, 51);
    chk("t4_overrun_count", ovr_cnt, 1);
    chk("t4_no_read_40000", saw4, 0);
    chk("t4_last_addr", last_addr, 20'h0033F);

    // Reset mid-burst at t+100, then a fresh row under random grant.
    set_mode(0);
    start_pulse(20'h00200);
    repeat (99) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    repeat (6) step();
    chk("t5_valids_before_reset", vcnt, 97);
    set_mode(2);
    start_pulse(20'h00200);
    wait_idle(1000);
    chk("t5_fresh_valid_count", vcnt, 320);

    // Random addresses, random grant, stray starts mid-burst.
    for (int k = 0; k < 3; k++) begin
      set_mode(2);
      start_pulse(20'($urandom));
      repeat ($urandom_range(5, 300)) step();
      if (busy_m) start_pulse(20'($urandom));
      wait_idle(1500);
      chk("t6_valid_count", vcnt, 320);
    end

    // Single-tuple row on the second instance.
    r1_en      = 1'b1;
    r1_start   = 1'b1;
    r1_addr_in = 20'h00010;
    step();
    repeat (8) step();
    r1_en = 1'b0;
    chk("r1_read_count", r1_rd, 1);
    chk("r1_read_addr", r1_addr_seen, 20'h00010);
    chk("r1_valid_count", r1_vld, 1);
    chk("r1_column", r1_col_seen, 0);
    chk("r1_data", r1_dat_seen, 24'h123456);
    chk("r1_busy_cycles", r1_busy_cyc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
